// File: rtl/axil_cmd_master.sv
// axil_cmd_master: single-outstanding AXI4-Lite initiator.
// Turns a valid/ready command stream (read or write of one 32-bit register)
// into one AXI-Lite transaction at a time and returns the read data and
// response code on a valid/ready response stream. A sticky timeout flag
// reports any AXI phase that waits too long. The transaction is never
// abandoned, so only reset can recover a stuck slave.
// Only DATA_W = 32 is meaningful because the strobe bus is fixed at 4 bits.

module axil_cmd_master #(
   parameter int ADDR_W  = 5,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 256
) (
   input  logic              s_axi_aclk,
   input  logic              s_axi_aresetn,

   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   input  logic [3:0]        cmd_wstrb,

   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_write,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic [1:0]        rsp_resp,
   output logic              timeout_err,

   output logic [ADDR_W-1:0] m_axi_awaddr,
   output logic              m_axi_awvalid,
   input  logic              m_axi_awready,
   output logic [DATA_W-1:0] m_axi_wdata,
   output logic [3:0]        m_axi_wstrb,
   output logic              m_axi_wvalid,
   input  logic              m_axi_wready,
   input  logic [1:0]        m_axi_bresp,
   input  logic              m_axi_bvalid,
   output logic              m_axi_bready,
   output logic [ADDR_W-1:0] m_axi_araddr,
   output logic              m_axi_arvalid,
   input  logic              m_axi_arready,
   input  logic [DATA_W-1:0] m_axi_rdata,
   input  logic [1:0]        m_axi_rresp,
   input  logic              m_axi_rvalid,
   output logic              m_axi_rready
);

   // A zero TIMEOUT still needs a legal one-bit counter; it simply never counts.
   localparam int              CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

   typedef enum logic [2:0] {
      IDLE,
      WR_REQ,
      WR_RESP,
      RD_REQ,
      RD_DATA,
      RSP
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                timeout_err_q, timeout_err_d;
   logic                cmd_ready_q, cmd_ready_d;
   logic                awvalid_q, awvalid_d;
   logic                wvalid_q, wvalid_d;
   logic                bready_q, bready_d;
   logic                arvalid_q, arvalid_d;
   logic                rready_q, rready_d;
   logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [3:0]          wstrb_q, wstrb_d;
   logic [ADDR_W-1:0]   araddr_q, araddr_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic                rsp_write_q, rsp_write_d;
   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic [1:0]          rsp_resp_q, rsp_resp_d;
   logic                waiting;

   // Transaction sequencing: next state and next value of every registered output.
   always_comb begin
      state_d     = state_q;
      cmd_ready_d = cmd_ready_q;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      bready_d    = bready_q;
      arvalid_d   = arvalid_q;
      rready_d    = rready_q;
      awaddr_d    = awaddr_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      araddr_d    = araddr_q;
      rsp_valid_d = rsp_valid_q;
      rsp_write_d = rsp_write_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_resp_d  = rsp_resp_q;

      unique case (state_q)
         IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               cmd_ready_d = 1'b0;
               if (cmd_write) begin
                  awaddr_d  = cmd_addr;
                  wdata_d   = cmd_wdata;
                  wstrb_d   = cmd_wstrb;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  state_d   = WR_REQ;
               end else begin
                  araddr_d  = cmd_addr;
                  arvalid_d = 1'b1;
                  state_d   = RD_REQ;
               end
            end
         end

         WR_REQ: begin
            if (awvalid_q && m_axi_awready) begin
               awvalid_d = 1'b0;
            end
            if (wvalid_q && m_axi_wready) begin
               wvalid_d = 1'b0;
            end
            if (!awvalid_d && !wvalid_d) begin
               bready_d = 1'b1;
               state_d  = WR_RESP;
            end
         end

         WR_RESP: begin
            if (m_axi_bvalid) begin
               bready_d    = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_write_d = 1'b1;
               rsp_rdata_d = '0;
               rsp_resp_d  = m_axi_bresp;
               state_d     = RSP;
            end
         end

         RD_REQ: begin
            if (m_axi_arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = RD_DATA;
            end
         end

         RD_DATA: begin
            if (m_axi_rvalid) begin
               rready_d    = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_write_d = 1'b0;
               rsp_rdata_d = m_axi_rdata;
               rsp_resp_d  = m_axi_rresp;
               state_d     = RSP;
            end
         end

         RSP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               cmd_ready_d = 1'b1;
               state_d     = IDLE;
            end
         end

         default: begin
            state_d     = IDLE;
            cmd_ready_d = 1'b1;
            awvalid_d   = 1'b0;
            wvalid_d    = 1'b0;
            bready_d    = 1'b0;
            arvalid_d   = 1'b0;
            rready_d    = 1'b0;
            rsp_valid_d = 1'b0;
         end
      endcase
   end

   // Stall watchdog: counts cycles spent waiting on the slave in the current phase.
   always_comb begin
      waiting = (state_q == WR_REQ) || (state_q == WR_RESP) ||
                (state_q == RD_REQ) || (state_q == RD_DATA);
      cnt_d         = cnt_q;
      timeout_err_d = timeout_err_q;
      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (waiting && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      if ((TIMEOUT != 0) && (cnt_d == CNT_MAX)) begin
         timeout_err_d = 1'b1;
      end
   end

   // State and output registers; reset drops every valid at once.
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         timeout_err_q <= 1'b0;
         cmd_ready_q   <= 1'b1;
         awvalid_q     <= 1'b0;
         wvalid_q      <= 1'b0;
         bready_q      <= 1'b0;
         arvalid_q     <= 1'b0;
         rready_q      <= 1'b0;
         awaddr_q      <= '0;
         wdata_q       <= '0;
         wstrb_q       <= '0;
         araddr_q      <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_write_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_resp_q    <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         timeout_err_q <= timeout_err_d;
         cmd_ready_q   <= cmd_ready_d;
         awvalid_q     <= awvalid_d;
         wvalid_q      <= wvalid_d;
         bready_q      <= bready_d;
         arvalid_q     <= arvalid_d;
         rready_q      <= rready_d;
         awaddr_q      <= awaddr_d;
         wdata_q       <= wdata_d;
         wstrb_q       <= wstrb_d;
         araddr_q      <= araddr_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_write_q   <= rsp_write_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_resp_q    <= rsp_resp_d;
      end
   end

   assign cmd_ready     = cmd_ready_q;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_write     = rsp_write_q;
   assign rsp_rdata     = rsp_rdata_q;
   assign rsp_resp      = rsp_resp_q;
   assign timeout_err   = timeout_err_q;
   assign m_axi_awaddr  = awaddr_q;
   assign m_axi_awvalid = awvalid_q;
   assign m_axi_wdata   = wdata_q;
   assign m_axi_wstrb   = wstrb_q;
   assign m_axi_wvalid  = wvalid_q;
   assign m_axi_bready  = bready_q;
   assign m_axi_araddr  = araddr_q;
   assign m_axi_arvalid = arvalid_q;
   assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Testbench for axil_cmd_master: a slave and command/response agent driven
// from a per-transaction timeline. Each transaction is described by the
// slave's stall cycles per phase; the expected cycle of every handshake and
// of the timeout flag follows from those stalls by plain arithmetic.

module tb_axil_cmd_master;

   localparam int ADDR_W  = 5;
   localparam int DATA_W  = 32;
   localparam int TIMEOUT = 8;
   localparam int NEVER   = 1 << 20;

   logic              clk;
   logic              rst_n;
   logic              cmd_valid, cmd_ready, cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic [3:0]        cmd_wstrb;
   logic              rsp_valid, rsp_ready, rsp_write;
   logic [DATA_W-1:0] rsp_rdata;
   logic [1:0]        rsp_resp;
   logic              timeout_err;
   logic [ADDR_W-1:0] awaddr, araddr;
   logic              awvalid, awready, wvalid, wready, bvalid, bready;
   logic              arvalid, arready, rvalid, rready;
   logic [DATA_W-1:0] wdata, rdata;
   logic [3:0]        wstrb;
   logic [1:0]        bresp, rresp;
   logic [6:0]        ctrl;

   int checks = 0;
   int errors = 0;
   bit model_err = 1'b0;

   axil_cmd_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
      .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
      .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .timeout_err(timeout_err),
      .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
      .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid),
      .m_axi_wready(wready), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid),
      .m_axi_bready(bready), .m_axi_araddr(araddr), .m_axi_arvalid(arvalid),
      .m_axi_arready(arready), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
      .m_axi_rvalid(rvalid), .m_axi_rready(rready)
   );

   assign ctrl = {cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          rst_before;
      bit          write;
      logic [4:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      int          daw, dw, db, dar, dr, drsp;
      logic [1:0]  resp;
      logic [31:0] rdata;
      bit          hold;
      int          exp_first;
      bit          exp_write;
      logic [31:0] exp_rdata;
      logic [1:0]  exp_resp;
      bit          exp_err;
   } vec_t;

   typedef struct {
      int aw_hs, w_hs, b_start, b_hs, ar_hs, r_start, r_hs, first, rsp_hs, rise;
   } tl_t;

   vec_t table_v[11];

   function automatic int maxi(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic vec_t mk(input bit rb, input bit wr, input logic [4:0] a,
                               input logic [31:0] wd, input logic [3:0] ws,
                               input int daw, input int dw, input int db,
                               input int dar, input int dr, input int drsp,
                               input logic [1:0] resp, input logic [31:0] rd,
                               input bit hold, input int ef, input logic [31:0] erd,
                               input logic [1:0] eresp, input bit eerr);
      vec_t v;
      v.rst_before = rb;  v.write = wr;  v.addr = a;  v.wdata = wd;  v.wstrb = ws;
      v.daw = daw;  v.dw = dw;  v.db = db;  v.dar = dar;  v.dr = dr;  v.drsp = drsp;
      v.resp = resp;  v.rdata = rd;  v.hold = hold;
      v.exp_first = ef;  v.exp_write = wr;  v.exp_rdata = erd;
      v.exp_resp = eresp;  v.exp_err = eerr;
      return v;
   endfunction

   // Cycle numbers relative to the accept cycle (0) from the slave's stalls.
   function automatic tl_t timeline(input vec_t v);
      tl_t t;
      int  both;
      t.aw_hs = 0;  t.w_hs = 0;  t.b_start = 0;  t.b_hs = 0;
      t.ar_hs = 0;  t.r_start = 0;  t.r_hs = 0;  t.rise = NEVER;
      if (v.write) begin
         t.aw_hs   = 1 + v.daw;
         t.w_hs    = 1 + v.dw;
         both      = maxi(t.aw_hs, t.w_hs);
         t.b_start = both + 1;
         t.b_hs    = t.b_start + v.db;
         t.first   = t.b_hs + 1;
         if (TIMEOUT > 0 && maxi(v.daw, v.dw) >= TIMEOUT) t.rise = 1 + TIMEOUT;
         else if (TIMEOUT > 0 && v.db >= TIMEOUT) t.rise = t.b_start + TIMEOUT;
      end else begin
         t.ar_hs   = 1 + v.dar;
         t.r_start = t.ar_hs + 1;
         t.r_hs    = t.r_start + v.dr;
         t.first   = t.r_hs + 1;
         if (TIMEOUT > 0 && v.dar >= TIMEOUT) t.rise = 1 + TIMEOUT;
         else if (TIMEOUT > 0 && v.dr >= TIMEOUT) t.rise = t.r_start + TIMEOUT;
      end
      t.rsp_hs = t.first + v.drsp;
      return t;
   endfunction

   // Reference model: what the requester should see for a transaction.
   function automatic vec_t modelTxn(input vec_t v, input bit err_in);
      tl_t t;
      t = timeline(v);
      v.exp_first = t.first;
      v.exp_write = v.write;
      v.exp_rdata = v.write ? 32'h0 : v.rdata;
      v.exp_resp  = v.resp;
      v.exp_err   = err_in || (t.rise != NEVER);
      return v;
   endfunction

   function automatic int pickDelay();
      if ($urandom_range(0, 5) == 0) return int'($urandom_range(6, 10));
      return int'($urandom_range(0, 2));
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, "_ctrl"}, 32'(ctrl), 32'(7'b1000000));
      checkOutput({tag, "_awaddr"}, 32'(awaddr), 32'h0);
      checkOutput({tag, "_wdata"}, wdata, 32'h0);
      checkOutput({tag, "_wstrb"}, 32'(wstrb), 32'h0);
      checkOutput({tag, "_araddr"}, 32'(araddr), 32'h0);
      checkOutput({tag, "_rsp"}, {29'h0, rsp_write, rsp_resp}, 32'h0);
      checkOutput({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
      checkOutput({tag, "_timeout_err"}, 32'(timeout_err), 32'h0);
   endtask

   task automatic idleInputs();
      cmd_valid = 1'b0;  cmd_write = 1'b0;  cmd_addr = '0;  cmd_wdata = '0;  cmd_wstrb = '0;
      rsp_ready = 1'b0;  awready = 1'b0;  wready = 1'b0;  bvalid = 1'b0;  bresp = '0;
      arready = 1'b0;  rvalid = 1'b0;  rdata = '0;  rresp = '0;
   endtask

   task automatic resetDut();
      @(negedge clk);
      rst_n = 1'b0;
      idleInputs();
      #1;
      checkReset("reset");
      @(negedge clk);
      rst_n = 1'b1;
      model_err = 1'b0;
   endtask

   // One complete command: cycle 0 is the accept cycle; every cycle is checked.
   task automatic applyStimulus(input vec_t v);
      tl_t        t;
      int         first_seen;
      bit         err_in;
      logic       last_err;
      logic [6:0] exp_ctrl;
      bit         e_aw, e_w, e_b, e_ar, e_r, e_rsp;
      t = timeline(v);
      err_in = model_err;
      first_seen = -1;
      last_err = 1'b0;
      for (int c = 0; c <= t.rsp_hs; c++) begin
         @(negedge clk);
         e_aw  = v.write && c >= 1 && c <= t.aw_hs;
         e_w   = v.write && c >= 1 && c <= t.w_hs;
         e_b   = v.write && c >= t.b_start && c <= t.b_hs;
         e_ar  = !v.write && c >= 1 && c <= t.ar_hs;
         e_r   = !v.write && c >= t.r_start && c <= t.r_hs;
         e_rsp = c >= t.first && c <= t.rsp_hs;
         exp_ctrl = {c == 0, e_aw, e_w, e_b, e_ar, e_r, e_rsp};
         checkOutput("ctrl{cmd_rdy,aw,w,b,ar,r,rsp}", 32'(ctrl), 32'(exp_ctrl));
         checkOutput("timeout_err", 32'(timeout_err), 32'(err_in || c >= t.rise));
         if (e_aw) checkOutput("awaddr", 32'(awaddr), 32'(v.addr));
         if (e_w) begin
            checkOutput("wdata", wdata, v.wdata);
            checkOutput("wstrb", 32'(wstrb), 32'(v.wstrb));
         end
         if (e_ar) checkOutput("araddr", 32'(araddr), 32'(v.addr));
         if (e_rsp) begin
            checkOutput("rsp_write", 32'(rsp_write), 32'(v.exp_write));
            checkOutput("rsp_rdata", rsp_rdata, v.exp_rdata);
            checkOutput("rsp_resp", 32'(rsp_resp), 32'(v.exp_resp));
         end
         if (rsp_valid && first_seen < 0) first_seen = c;
         last_err = timeout_err;

         if (c == 0) begin
            cmd_valid = 1'b1;  cmd_write = v.write;  cmd_addr = v.addr;
            cmd_wdata = v.wdata;  cmd_wstrb = v.wstrb;
         end else if (v.hold && c >= t.first) begin
            cmd_valid = 1'b1;  cmd_write = 1'b1;  cmd_addr = 5'h1F;
            cmd_wdata = 32'hBAD0_BAD0;  cmd_wstrb = 4'hF;
         end else begin
            cmd_valid = 1'b0;
         end
         awready = v.write && c == t.aw_hs;
         wready  = v.write && c == t.w_hs;
         bvalid  = v.write && c == t.b_hs;
         bresp   = bvalid ? v.resp : ~v.resp;
         arready = !v.write && c == t.ar_hs;
         rvalid  = !v.write && c == t.r_hs;
         rdata   = rvalid ? v.rdata : ~v.rdata;
         rresp   = rvalid ? v.resp : ~v.resp;
         rsp_ready = (c == t.rsp_hs);
      end
      checkOutput("rsp_latency", 32'(first_seen), 32'(v.exp_first));
      checkOutput("err_final", 32'(last_err), 32'(v.exp_err));
      model_err = err_in || (t.rise != NEVER);
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec_t v;
      rst_n = 1'b0;
      idleInputs();

      //                  rb wr addr   wdata         strb daw dw db dar dr drsp resp  rdata         hold first exp_rdata   eresp err
      table_v[0]  = mk(0, 1, 5'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0,  0, 0, 2'd0, 32'h0,        0, 3,  32'h0,        2'd0, 0);
      table_v[1]  = mk(0, 1, 5'h04, 32'hCAFEF00D, 4'hF, 3, 0, 0, 0,  0, 0, 2'd0, 32'h0,        0, 6,  32'h0,        2'd0, 0);
      table_v[2]  = mk(0, 1, 5'h08, 32'hA5A55A5A, 4'h3, 0, 2, 0, 0,  0, 0, 2'd0, 32'h0,        0, 5,  32'h0,        2'd0, 0);
      table_v[3]  = mk(0, 1, 5'h1F, 32'h00000000, 4'h5, 1, 1, 2, 0,  0, 0, 2'd3, 32'h0,        0, 6,  32'h0,        2'd3, 0);
      table_v[4]  = mk(0, 0, 5'h10, 32'h0,        4'h0, 0, 0, 0, 0,  5, 0, 2'd2, 32'h12345678, 0, 8,  32'h12345678, 2'd2, 0);
      table_v[5]  = mk(0, 0, 5'h00, 32'h0,        4'h0, 0, 0, 0, 2,  0, 4, 2'd3, 32'hFFFFFFFF, 1, 5,  32'hFFFFFFFF, 2'd3, 0);
      table_v[6]  = mk(0, 1, 5'h0C, 32'h01020304, 4'h9, 0, 0, 0, 0,  0, 0, 2'd2, 32'h0,        0, 3,  32'h0,        2'd2, 0);
      table_v[7]  = mk(0, 1, 5'h14, 32'h11223344, 4'hF, 0, 0, 7, 0,  0, 0, 2'd1, 32'h0,        0, 10, 32'h0,        2'd1, 0);
      table_v[8]  = mk(0, 0, 5'h18, 32'h0,        4'h0, 0, 0, 0, 12, 0, 0, 2'd0, 32'h0BADF00D, 0, 15, 32'h0BADF00D, 2'd0, 1);
      table_v[9]  = mk(1, 0, 5'h1C, 32'h0,        4'h0, 0, 0, 0, 0,  8, 0, 2'd1, 32'h55AA55AA, 0, 11, 32'h55AA55AA, 2'd1, 1);
      table_v[10] = mk(1, 1, 5'h06, 32'h87654321, 4'hC, 8, 2, 0, 0,  0, 1, 2'd0, 32'h0,        0, 11, 32'h0,        2'd0, 1);

      resetDut();
      for (int i = 0; i < 11; i++) begin
         if (table_v[i].rst_before) resetDut();
         applyStimulus(table_v[i]);
      end

      // Reset asserted while the write waits for its B response.
      @(negedge clk);
      idleInputs();
      cmd_valid = 1'b1;  cmd_write = 1'b1;  cmd_addr = 5'h0A;
      cmd_wdata = 32'h600DCAFE;  cmd_wstrb = 4'hF;
      @(negedge clk);
      checkOutput("midrst_wr_req_ctrl", 32'(ctrl), 32'(7'b0110000));
      cmd_valid = 1'b0;  awready = 1'b1;  wready = 1'b1;
      @(negedge clk);
      checkOutput("midrst_wr_resp_ctrl", 32'(ctrl), 32'(7'b0001000));
      awready = 1'b0;  wready = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_reset_ctrl", 32'(ctrl), 32'(7'b1000000));
      checkOutput("async_reset_timeout_err", 32'(timeout_err), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      model_err = 1'b0;
      applyStimulus(mk(0, 1, 5'h02, 32'h13579BDF, 4'h3, 0, 0, 0, 0, 0, 0, 2'd0, 32'h0,
                       0, 3, 32'h0, 2'd0, 0));

      // Randomized transactions checked against the timeline model.
      for (int i = 0; i < 40; i++) begin
         if (i % 10 == 0) resetDut();
         v.rst_before = 1'b0;
         v.write = 1'($urandom_range(0, 1));
         v.addr  = 5'($urandom);
         v.wdata = $urandom;
         v.wstrb = 4'($urandom);
         v.daw   = pickDelay();
         v.dw    = pickDelay();
         v.db    = pickDelay();
         v.dar   = pickDelay();
         v.dr    = pickDelay();
         v.drsp  = int'($urandom_range(0, 3));
         v.resp  = 2'($urandom);
         v.rdata = $urandom;
         v.hold  = 1'($urandom_range(0, 1));
         v = modelTxn(v, model_err);
         applyStimulus(v);
      end

      @(negedge clk);
      idleInputs();
      checkOutput("final_idle_ctrl", 32'(ctrl), 32'(7'b1000000));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/axil_cmd_master.md
Name: axil_cmd_master

Overview:
- Single-outstanding AXI4-Lite master (initiator) that drives the coprocessor's AXI-Lite slave port.
- Converts a simple valid/ready command stream (read or write, 5-bit register address) into AXI-Lite transactions.
- Returns read data and response codes on a valid/ready response stream.
- Used by on-chip sequencers and by the system testbench to load operands, issue operations and read results.

Parameters:
- ADDR_W, 5, AXI address width (matches the slave register window).
- DATA_W, 32, AXI data width; only 32 is supported.
- TIMEOUT, 256, cycles a phase may wait for a handshake before timeout_err is set; 0 disables the check.

Ports:
- s_axi_aclk  in  1  clock; all logic on rising edge.
- s_axi_aresetn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  DATA_W  write data.
- cmd_wstrb  in  4  write byte strobes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready.
- rsp_write  out  1  response belongs to a write.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP.
- timeout_err  out  1  sticky stall flag.
- m_axi_awaddr  out  ADDR_W  write address.
- m_axi_awvalid  out  1  write address valid.
- m_axi_awready  in  1  write address ready.
- m_axi_wdata  out  DATA_W  write data.
- m_axi_wstrb  out  4  write strobes.
- m_axi_wvalid  out  1  write data valid.
- m_axi_wready  in  1  write data ready.
- m_axi_bresp  in  2  write response.
- m_axi_bvalid  in  1  write response valid.
- m_axi_bready  out  1  write response ready.
- m_axi_araddr  out  ADDR_W  read address.
- m_axi_arvalid  out  1  read address valid.
- m_axi_arready  in  1  read address ready.
- m_axi_rdata  in  DATA_W  read data.
- m_axi_rresp  in  2  read response.
- m_axi_rvalid  in  1  read data valid.
- m_axi_rready  out  1  read data ready.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE; timeout counter 0.
  - All *valid/*ready outputs 0, except cmd_ready=1.
  - All address/data/resp/strobe outputs 0; timeout_err 0.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- IDLE: cmd_ready=1.
  - On accept: register addr/wdata/wstrb/write.
  - Write -> WR_REQ with awvalid=wvalid=1 next cycle.
  - Read -> RD_REQ with arvalid=1 next cycle.
- WR_REQ: awvalid and wvalid deassert independently, each the cycle after its own handshake.
  - AW and W may complete in either order or in the same cycle.
  - Leave to WR_RESP only once both have completed.
- WR_RESP: bready=1. On bvalid:
  - Capture bresp; rsp_write=1, rsp_rdata=0.
  - bready=0; -> RSP.
- RD_REQ: arvalid=1 until arready, then -> RD_DATA.
- RD_DATA: rready=1. On rvalid:
  - Capture rdata/rresp; rsp_write=0; rready=0; -> RSP.
- RSP: rsp_valid=1 with stable payload until rsp_ready, then -> IDLE.
  - cmd_ready=0 throughout, so at most one command is outstanding.
- Valid/payload stability:
  - Once asserted, any AXI valid stays high with a stable payload until its handshake; it is never withdrawn except by reset.
  - bready and rready are 0 outside their states.
- Address and data pass through unmodified; no alignment checks.
- rsp_resp carries SLVERR/DECERR verbatim and does not change the flow.
- Latency against a zero-wait slave:
  - Write: accept at cycle 0, AW+W handshake at 1, B at 2, rsp_valid at 3.
  - Read: accept at 0, AR at 1, R at 2, rsp_valid at 3.
  - Next cmd_ready is the cycle after rsp handshake.
- Timeout:
  - Counter clears on every state change.
  - Counter increments each cycle in WR_REQ, WR_RESP, RD_REQ and RD_DATA.
  - When it reaches TIMEOUT, timeout_err is set and held until reset. The transaction keeps waiting and is never abandoned.
  - The counter saturates.
  - Counter width is clog2(TIMEOUT+1).
- Reset mid-transaction: the block returns to IDLE immediately and all valids drop asynchronously. Any in-flight slave transaction is lost.

Test Plan:
- Zero-wait slave; write addr 0x04, data 0xDEADBEEF, strb 0xF -> AW+W handshake at cycle 1, bready at 2, rsp_valid at 3 with rsp_write=1, rsp_resp=0, rsp_rdata=0.
- awready held 0 for 3 cycles and wready immediate -> wvalid drops at cycle 2, awvalid holds with awaddr 0x04 stable until cycle 4, bready only after both.
- Read addr 0x10; rvalid delayed 5 cycles with rdata 0x12345678, rresp 2 -> rsp_valid with rdata 0x12345678, rsp_resp 2, rsp_write=0.
- rsp_ready held low 4 cycles with cmd_valid high -> rsp payload stable and cmd_ready=0 throughout; new command accepted the cycle after rsp handshake.
- TIMEOUT=8, arready never asserted -> timeout_err rises after 8 cycles in RD_REQ, arvalid stays high; later arready plus R completes normally and timeout_err stays 1.
- Assert s_axi_aresetn low during WR_RESP -> all AXI valids/readies 0 and cmd_ready 1 without waiting for a clock edge; next write completes normally.
